cross_bar_slave_arbiter: RTL and testbench
==========================================

Name: cross_bar_slave_arbiter

Overview:
- One instance per slave port of the 4x4 cross_bar.
- Arbitrates between masters whose decoded address (addr[31:30]) targets this slave, using round-robin priority.
- Owns the slave for the full transaction: until ack for a write, until resp for a read.
- Drives the request-path grant and the response-path select consumed by the commutation block.

Parameters:
N_MASTERS, 4, number of requesting masters (power of two, >=2)
TIMEOUT_CYCLES, 256, watchdog limit in cycles; only used with CB_ARB_TIMEOUT_EN

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
req_i  input  N_MASTERS  per-master request already decoded for this slave
cmd_i  input  N_MASTERS  per-master cmd bit: 0 = write, 1 = read
slave_ack_i  input  1  slave accepted the request (1-cycle pulse)
slave_resp_i  input  1  slave read data valid (1-cycle pulse)
grant_o  output  N_MASTERS  one-hot grant; request path (addr/cmd/wdata to slave, ack back to master)
resp_sel_o  output  N_MASTERS  one-hot select; response path (resp/rdata back to owner)
owner_o  output  $clog2(N_MASTERS)  index of the current owner; valid while busy_o
busy_o  output  1  slave owned (state != IDLE)
timeout_o  output  1  1-cycle pulse on watchdog abort; present only with CB_ARB_TIMEOUT_EN

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; grant_o=0, resp_sel_o=0, owner_o=0, busy_o=0, timeout_o=0.
  - Priority pointer = 0, so master 0 has highest priority.
  - Reset mid-transaction drops ownership immediately; no ack or resp is forwarded afterwards.
- State machine (states IDLE, REQ, RESP):
  - IDLE:
    - If any req_i bit is set, pick the first set bit scanning ptr, ptr+1, ... modulo N_MASTERS.
    - Register owner, latch owner_cmd = cmd_i[owner], go to REQ.
    - grant_o goes one-hot on the next cycle (1-cycle arbitration latency).
    - slave_ack_i and slave_resp_i are ignored in IDLE.
  - REQ:
    - grant_o[owner]=1; owner_cmd is frozen (later cmd_i changes are ignored).
    - slave_ack_i with owner_cmd=0 (write): go to IDLE, ptr <= owner+1 (wraps).
    - slave_ack_i with owner_cmd=1 and slave_resp_i=0: go to RESP.
    - slave_ack_i and slave_resp_i in the same cycle (read): transaction complete, go to IDLE, ptr <= owner+1.
    - req_i[owner] drops before ack: abort, go to IDLE, ptr <= owner+1, nothing forwarded.
  - RESP:
    - grant_o=0 and resp_sel_o[owner]=1.
    - New requests stay pending; there is no request pipelining.
    - On slave_resp_i: go to IDLE, ptr <= owner+1. resp_sel_o is held through the resp cycle and drops the cycle after.
- The earliest re-grant after completion is 2 cycles after the completing ack/resp (one IDLE cycle, then grant).
- Invariants:
  - grant_o and resp_sel_o are never both non-zero.
  - Each is zero or one-hot.
  - owner_o is stable throughout REQ and RESP.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: CB_ARB_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears on entry to REQ or RESP and increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES with no completing ack/resp: go to IDLE, ptr <= owner+1, timeout_o pulses for 1 cycle.
  - A completing event in the same cycle as the limit wins; no timeout is raised.
- Undefined: no counter and no timeout_o port; a missing slave ack/resp hangs the slave port indefinitely.

Decomposition:
- Package cross_bar_pkg holds:
  - N_MASTERS_DEF=4 and ADDR_SEL_MSB/LSB=31/30.
  - CMD_WRITE=1'b0 and CMD_READ=1'b1.
  - Enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_RESP}.
- Sub-module rr_pick (combinational round-robin picker: req vector + ptr -> one-hot + index + any) is reused by other arbiters.

Test Plan:
1. Single write: req_i=0100 with cmd=0 from cycle 10 → grant_o=0100 at cycle 11, owner_o=2. slave_ack_i at cycle 15 → grant_o=0 and busy_o=0 at cycle 16.
2. Read with separate resp: req_i=0001 with cmd=1, ack at T → grant_o=0 and resp_sel_o=0001 at T+1. slave_resp_i at T+5 → resp_sel_o=0 at T+6. rdata=10 is routed to master 0.
3. Round-robin fairness: req_i=1111 held, writes acked 3 cycles after each grant → grant order is 0,1,2,3,0, with one IDLE cycle between consecutive grants.
4. Contention during read: master 0 reads, master 2 requests while in RESP → master 2 not granted until the cycle after resp + 1; resp_sel_o never overlaps grant_o.
5. Boundaries:
   - Spurious ack in IDLE → no state change.
   - Simultaneous ack+resp on a read → IDLE directly.
   - Owner drops req before ack → abort to IDLE, next master granted.
   - rst=1 while in RESP → all outputs 0 on the next cycle, ptr=0.
6. With CB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: grant with no ack → timeout_o pulses 8 cycles after grant, state IDLE, ptr advanced past the owner.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// Shared definitions for the 4x4 cross_bar: default sizing, address decode
// field, command encoding and the slave arbiter state type.
package cross_bar_pkg;

  localparam int unsigned N_MASTERS_DEF = 4;
  localparam int unsigned ADDR_SEL_MSB  = 31;
  localparam int unsigned ADDR_SEL_LSB  = 30;
  localparam int unsigned ADDR_SEL_W    = ADDR_SEL_MSB - ADDR_SEL_LSB + 1;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  // Slave index selected by a master address.
  function automatic logic [ADDR_SEL_W-1:0] addr_sel(input logic [31:0] addr);
    return addr[ADDR_SEL_MSB:ADDR_SEL_LSB];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first set request bit found
// scanning ptr, ptr+1, ... modulo N. N must be a power of two so the index
// arithmetic wraps naturally.
// Ports:
//   req     - request vector
//   ptr     - highest-priority index
//   grant_c - one-hot of the picked request (zero when none)
//   idx_c   - index of the picked request (zero when none)
//   any_c   - at least one request is set
module rr_pick
  import cross_bar_pkg::*;
#(
  parameter  int unsigned N  = N_MASTERS_DEF,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  logic [IW-1:0] cand;

  // Scan from the far end back toward ptr so the nearest hit is written last.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = ptr + IW'(k);
      if (req[cand]) begin
        idx_c = cand;
        any_c = 1'b1;
      end
    end
    if (any_c) grant_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/cross_bar_slave_arbiter.sv
// Per-slave round-robin arbiter for the 4x4 cross_bar. The winning master owns
// the slave for the whole transaction: until ack for a write, until resp for a
// read. Drives the request-path grant and the response-path select.
// Optional watchdog: define CB_ARB_TIMEOUT_EN to abort transactions that see
// no completing ack/resp within TIMEOUT_CYCLES and pulse timeout_o.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   req_i         - per-master request decoded for this slave
//   cmd_i         - per-master command (0 write, 1 read)
//   slave_ack_i   - slave accepted the request (pulse)
//   slave_resp_i  - slave read data valid (pulse)
//   grant_o       - one-hot request-path grant
//   resp_sel_o    - one-hot response-path select
//   owner_o       - index of current owner, valid while busy_o
//   busy_o        - slave is owned
//   timeout_o     - watchdog abort pulse (CB_ARB_TIMEOUT_EN only)
module cross_bar_slave_arbiter
  import cross_bar_pkg::*;
#(
  parameter  int unsigned N_MASTERS      = N_MASTERS_DEF,
  parameter  int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned IW             = $clog2(N_MASTERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [N_MASTERS-1:0] cmd_i,
  input  logic                 slave_ack_i,
  input  logic                 slave_resp_i,
  output logic [N_MASTERS-1:0] grant_o,
  output logic [N_MASTERS-1:0] resp_sel_o,
  output logic [IW-1:0]        owner_o,
`ifdef CB_ARB_TIMEOUT_EN
  output logic                 timeout_o,
`endif
  output logic                 busy_o
);

  arb_state_t           state_q, state_d;
  logic                 cmd_q, cmd_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_d;
  logic [N_MASTERS-1:0] grant_d, resp_sel_d;

  logic [N_MASTERS-1:0] pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

`ifdef CB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_d;
  logic          expire;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  rr_pick #(.N(N_MASTERS)) u_pick (
    .req     (req_i),
    .ptr     (ptr_q),
    .grant_c (pick_onehot),
    .idx_c   (pick_idx),
    .any_c   (pick_any)
  );

  // Next-state, owner bookkeeping and next registered outputs.
  always_comb begin
    state_d = state_q;
    owner_d = owner_o;
    cmd_d   = cmd_q;
    ptr_d   = ptr_q;
`ifdef CB_ARB_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
    expire    = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

    case (state_q)
      ARB_IDLE: begin
        // ack/resp are ignored here; only new requests matter.
        if (pick_any) begin
          state_d = ARB_REQ;
          owner_d = pick_idx;
          cmd_d   = |(cmd_i & pick_onehot);
        end
      end

      ARB_REQ: begin
`ifdef CB_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        // A completing ack beats an abort or a timeout in the same cycle.
        if (slave_ack_i) begin
          if (cmd_q == CMD_READ && !slave_resp_i) begin
            state_d = ARB_RESP;
`ifdef CB_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
          end else begin
            state_d = ARB_IDLE;
            ptr_d   = owner_o + IW'(1);
          end
        end else if (!req_i[owner_o]) begin
          state_d = ARB_IDLE;
          ptr_d   = owner_o + IW'(1);
        end
`ifdef CB_ARB_TIMEOUT_EN
        else if (expire) begin
          state_d   = ARB_IDLE;
          ptr_d     = owner_o + IW'(1);
          timeout_d = 1'b1;
        end
`endif
      end

      ARB_RESP: begin
`ifdef CB_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        if (slave_resp_i) begin
          state_d = ARB_IDLE;
          ptr_d   = owner_o + IW'(1);
        end
`ifdef CB_ARB_TIMEOUT_EN
        else if (expire) begin
          state_d   = ARB_IDLE;
          ptr_d     = owner_o + IW'(1);
          timeout_d = 1'b1;
        end
`endif
      end

      default: state_d = ARB_IDLE;
    endcase

    // Outputs follow the next state so they appear one cycle after the decision.
    grant_d    = '0;
    resp_sel_d = '0;
    if (state_d == ARB_REQ)  grant_d[owner_d]    = 1'b1;
    if (state_d == ARB_RESP) resp_sel_d[owner_d] = 1'b1;
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      cmd_q      <= CMD_WRITE;
      ptr_q      <= '0;
      owner_o    <= '0;
      grant_o    <= '0;
      resp_sel_o <= '0;
      busy_o     <= 1'b0;
`ifdef CB_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_o  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      ptr_q      <= ptr_d;
      owner_o    <= owner_d;
      grant_o    <= grant_d;
      resp_sel_o <= resp_sel_d;
      busy_o     <= (state_d != ARB_IDLE);
`ifdef CB_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_o  <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_cross_bar_slave_arbiter.sv
// Directed self-checking bench for cross_bar_slave_arbiter (4 masters).
// Each step drives one cycle of inputs, queues the outputs expected after
// the following clock edge, then pops and compares them.
module tb_cross_bar_slave_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, cmd;
  logic       ack, resp;
  logic [3:0] grant, rsel;
  logic [1:0] owner;
  logic       busy;
`ifdef CB_ARB_TIMEOUT_EN
  logic       tmo;
`endif

  typedef struct {
    logic [3:0] g;
    logic [3:0] rs;
    logic [1:0] o;
    logic       b;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic exp_to   = 1'b0;

  always #5 clk = ~clk;

  cross_bar_slave_arbiter #(.N_MASTERS(4), .TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .cmd_i        (cmd),
    .slave_ack_i  (ack),
    .slave_resp_i (resp),
    .grant_o      (grant),
    .resp_sel_o   (rsel),
    .owner_o      (owner),
`ifdef CB_ARB_TIMEOUT_EN
    .timeout_o    (tmo),
`endif
    .busy_o       (busy)
  );

  task automatic chk(input logic [7:0] obs, input logic [7:0] expv, input string tag);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs, queue expected outputs, compare after the edge.
  task automatic step(input logic r_rst, input logic [3:0] r, input logic [3:0] c,
                      input logic a, input logic s,
                      input logic [3:0] eg, input logic [3:0] ers,
                      input logic [1:0] eo, input logic eb, input string tag);
    exp_t e, got;
    @(negedge clk);
    rst  = r_rst;
    req  = r;
    cmd  = c;
    ack  = a;
    resp = s;
    e.g = eg; e.rs = ers; e.o = eo; e.b = eb; e.to = exp_to; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({4'b0, grant}, {4'b0, got.g},  {got.tag, "/grant"});
    chk({4'b0, rsel},  {4'b0, got.rs}, {got.tag, "/resp_sel"});
    chk({7'b0, busy},  {7'b0, got.b},  {got.tag, "/busy"});
    if (got.b) chk({6'b0, owner}, {6'b0, got.o}, {got.tag, "/owner"});
`ifdef CB_ARB_TIMEOUT_EN
    chk({7'b0, tmo}, {7'b0, got.to}, {got.tag, "/timeout"});
`endif
    chk({7'b0, (|grant) && (|rsel)}, 8'h00, {got.tag, "/overlap"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; cmd = '0; ack = 1'b0; resp = 1'b0;

    // Reset state
    step(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, "reset");
    step(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, "reset2");
    step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, "idle");

    // Single write from master 2; ptr -> 3 afterwards
    step(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 2'd2, 1, "t1_grant");
    for (int k = 0; k < 3; k++)
      step(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 2'd2, 1, "t1_hold");
    step(0, 4'b0100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd0, 0, "t1_ack");
    step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, "t1_idle");

    // Spurious ack/resp in IDLE
    step(0, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000, 2'd0, 0, "spurious");
    step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, "spurious2");

    // Read with separate resp from master 0; ptr -> 1
    step(0, 4'b0001, 4'b0001, 0, 0, 4'b0001, 4'b0000, 2'd0, 1, "t2_grant");
    step(0, 4'b0001, 4'b0001, 1, 0, 4'b0000, 4'b0001, 2'd0, 1, "t2_ack");
    for (int k = 0; k < 3; k++)
      step(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0001, 2'd0, 1, "t2_wait");
    step(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 2'd0, 0, "t2_resp");

    // Master 2 requests while master 0 sits in RESP; ptr ends at 3
    step(0, 4'b0001, 4'b0001, 0, 0, 4'b0001, 4'b0000, 2'd0, 1, "t4_grant");
    step(0, 4'b0001, 4'b0001, 1, 0, 4'b0000, 4'b0001, 2'd0, 1, "t4_ack");
    for (int k = 0; k < 2; k++)
      step(0, 4'b0100, 4'b0000, 0, 0, 4'b0000, 4'b0001, 2'd0, 1, "t4_pend");
    step(0, 4'b0100, 4'b0000, 0, 1, 4'b0000, 4'b0000, 2'd0, 0, "t4_resp");
    step(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 2'd2, 1, "t4_grant2");
    step(0, 4'b0100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd0, 0, "t4_ack2");

    // Read from master 1 completed by simultaneous ack+resp; ptr -> 2
    step(0, 4'b0010, 4'b0010, 0, 0, 4'b0010, 4'b0000, 2'd1, 1, "rw_grant");
    step(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 2'd1, 1, "rw_cmdchg");
    step(0, 4'b0010, 4'b0000, 1, 1, 4'b0000, 4'b0000, 2'd0, 0, "rw_ackresp");

    // Owner (master 3) drops request before ack; master 0 is next
    step(0, 4'b1001, 4'b0000, 0, 0, 4'b1000, 4'b0000, 2'd3, 1, "ab_grant");
    step(0, 4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, "ab_drop");
    step(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000, 2'd0, 1, "ab_next");
    step(0, 4'b0001, 4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd0, 0, "ab_ack");

    // Master 3 read with cmd changed after grant (stays a read), reset in RESP
    step(0, 4'b1000, 4'b1000, 0, 0, 4'b1000, 4'b0000, 2'd3, 1, "rs_grant");
    step(0, 4'b1000, 4'b0000, 0, 0, 4'b1000, 4'b0000, 2'd3, 1, "rs_cmdchg");
    step(0, 4'b1000, 4'b0000, 1, 0, 4'b0000, 4'b1000, 2'd3, 1, "rs_frozen");
    step(1, 4'b1000, 4'b0000, 0, 1, 4'b0000, 4'b0000, 2'd0, 0, "rs_reset");

    // Fairness with all masters requesting after reset: order 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      step(0, 4'b1111, 4'b0000, 0, 0, 4'(1 << (k % 4)), 4'b0000, 2'(k % 4), 1, "rr_grant");
      step(0, 4'b1111, 4'b0000, 0, 0, 4'(1 << (k % 4)), 4'b0000, 2'(k % 4), 1, "rr_hold");
      step(0, 4'b1111, 4'b0000, 0, 0, 4'(1 << (k % 4)), 4'b0000, 2'(k % 4), 1, "rr_hold");
      step(0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd0, 0, "rr_ack");
    end

`ifdef CB_ARB_TIMEOUT_EN
    // Watchdog: ptr is 1, master 2 granted and never acked
    step(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 2'd2, 1, "to_grant");
    for (int k = 0; k < 7; k++)
      step(0, 4'b0100, 4'b0000, 0, 0, 4'b0100, 4'b0000, 2'd2, 1, "to_wait");
    exp_to = 1'b1;
    step(0, 4'b0101, 4'b0000, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, "to_fire");
    exp_to = 1'b0;
    step(0, 4'b0101, 4'b0000, 0, 0, 4'b0001, 4'b0000, 2'd0, 1, "to_ptr");
    step(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 4'b0000, 2'd0, 0, "to_done");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
